// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: data width, NOP encoding,
// fetch FSM states and the PC alignment helper.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch performance counters: memory wait cycles and redirects.
import cpu_pkg::*;

module fetch_perf_cnt (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wait_inc_i,
  input  logic            redirect_inc_i,
  output logic [XLEN-1:0] wait_cycles_o,
  output logic [XLEN-1:0] redirect_cnt_o
);

  localparam logic [XLEN-1:0] CNT_MAX = '1;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wait_cycles_o  <= '0;
      redirect_cnt_o <= '0;
    end else begin
      if (wait_inc_i && (wait_cycles_o != CNT_MAX))
        wait_cycles_o <= wait_cycles_o + 1'b1;
      if (redirect_inc_i && (redirect_cnt_o != CNT_MAX))
        redirect_cnt_o <= redirect_cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem valid/ready handshake
// and feeds IF/ID. Optional counters are built with FETCH_PERF_CNT_EN.
//
// state | meaning
// FETCH | request outstanding at PC
// HOLD  | instruction captured while stalled, no request
// DROP  | request outstanding but its result is stale (redirect pending)
import cpu_pkg::*;

module fetch_unit #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_write_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [XLEN-1:0] imem_data_i,
  output logic [XLEN-1:0] PC_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] wait_cycles_o,
  output logic [XLEN-1:0] redirect_cnt_o
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_buf;
  logic [XLEN-1:0] saved_target;

  assign PC_o        = pc;
  assign imem_addr_o = pc;

  // Outputs are gated by reset so nothing leaks while rst_i is low.
  always_comb begin
    imem_req_o = 1'b0;
    valid_o    = 1'b0;
    inst_o     = NOP_INST;
    if (rst_i) begin
      unique case (state)
        FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ready_i && !branch_i) begin
            valid_o = 1'b1;
            inst_o  = imem_data_i;
          end
        end
        HOLD: begin
          valid_o = 1'b1;
          inst_o  = hold_buf;
        end
        DROP: imem_req_o = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= FETCH;
      pc           <= align_pc(RESET_PC);
      hold_buf     <= '0;
      saved_target <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready_i) begin
            if (branch_i) begin
              pc <= align_pc(branch_target_i);
            end else if (pc_write_i) begin
              pc <= align_pc(pc + 32'd4);
            end else begin
              hold_buf <= imem_data_i;
              state    <= HOLD;
            end
          end else if (branch_i) begin
            saved_target <= align_pc(branch_target_i);
            state        <= DROP;
          end
        end
        HOLD: begin
          if (branch_i) begin
            pc    <= align_pc(branch_target_i);
            state <= FETCH;
          end else if (pc_write_i) begin
            pc    <= align_pc(pc + 32'd4);
            state <= FETCH;
          end
        end
        DROP: begin
          // The newest redirect wins, even one arriving in the ready cycle.
          if (branch_i)
            saved_target <= align_pc(branch_target_i);
          if (imem_ready_i) begin
            pc    <= branch_i ? align_pc(branch_target_i) : saved_target;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wait_inc_i     (imem_req_o && !imem_ready_i),
    .redirect_inc_i (branch_i && rst_i),
    .wait_cycles_o  (wait_cycles_o),
    .redirect_cnt_o (redirect_cnt_o)
  );
`else
  // Counter ports and logic are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random bench for fetch_unit against an instruction-stream model.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC  = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        pc_write_i = 1'b1;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b1;
  logic [31:0] imem_data_i = '0;
  logic [31:0] PC_o;
  logic [31:0] inst_o;
  logic        valid_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] wait_cycles_o;
  logic [31:0] redirect_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  // Model: the PC to fetch next, an instruction parked by a stall, and a
  // redirect whose in-flight fetch must be thrown away.
  logic [31:0] m_pc;
  logic        m_holding;
  logic [31:0] m_held;
  logic        m_stale;
  logic [31:0] m_stale_tgt;
  longint      m_wait;
  longint      m_redir;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_write_i      (pc_write_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_data_i     (imem_data_i),
    .PC_o            (PC_o),
    .inst_o          (inst_o),
    .valid_o         (valid_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .wait_cycles_o   (wait_cycles_o),
    .redirect_cnt_o  (redirect_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Check one cycle's outputs against the model, then advance across the edge.
  task automatic step();
    logic        e_req, e_valid;
    logic [31:0] e_inst;
    #1;
    if (!rst_i) begin
      e_req = 1'b0; e_valid = 1'b0; e_inst = NOP;
    end else begin
      e_req   = !m_holding;
      e_valid = m_holding || (!m_stale && imem_ready_i && !branch_i);
      e_inst  = m_holding ? m_held : (e_valid ? imem_data_i : NOP);
    end
    chk("req",   {31'b0, imem_req_o}, {31'b0, e_req});
    chk("addr",  imem_addr_o, m_pc);
    chk("pc",    PC_o, m_pc);
    chk("valid", {31'b0, valid_o}, {31'b0, e_valid});
    chk("inst",  inst_o, e_inst);
`ifdef FETCH_PERF_CNT_EN
    chk("wait_cnt",  wait_cycles_o,  m_wait[31:0]);
    chk("redir_cnt", redirect_cnt_o, m_redir[31:0]);
`endif
    if (!rst_i) begin
      m_pc = al(RPC); m_holding = 0; m_stale = 0; m_held = '0;
      m_wait = 0; m_redir = 0;
    end else begin
      if (e_req && !imem_ready_i && m_wait < 64'hFFFF_FFFF) m_wait++;
      if (branch_i && m_redir < 64'hFFFF_FFFF) m_redir++;
      if (m_holding) begin
        if (branch_i) begin m_pc = al(branch_target_i); m_holding = 0; end
        else if (pc_write_i) begin m_pc = m_pc + 32'd4; m_holding = 0; end
      end else if (m_stale) begin
        if (branch_i) m_stale_tgt = al(branch_target_i);
        if (imem_ready_i) begin m_pc = m_stale_tgt; m_stale = 0; end
      end else if (imem_ready_i) begin
        if (branch_i) m_pc = al(branch_target_i);
        else if (pc_write_i) m_pc = m_pc + 32'd4;
        else begin m_holding = 1; m_held = imem_data_i; end
      end else if (branch_i) begin
        m_stale = 1; m_stale_tgt = al(branch_target_i);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic pw, input logic br,
                       input logic [31:0] tgt, input logic [31:0] data);
    imem_ready_i = rdy; pc_write_i = pw; branch_i = br;
    branch_target_i = tgt; imem_data_i = data;
  endtask

  initial begin
    m_pc = '0; m_holding = 0; m_held = '0; m_stale = 0; m_stale_tgt = '0;
    m_wait = 0; m_redir = 0;

    // Reset
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    m_pc = RPC;
    step();
    step();
    chk("reset_pc", PC_o, RPC);

    // Zero-wait streaming from RESET_PC
    rst_i = 1'b1;
    drive(1, 1, 0, '0, 32'h1111_0001); step();
    drive(1, 1, 0, '0, 32'h1111_0002); step();
    drive(1, 1, 0, '0, 32'h1111_0003); step();
    chk("stream_pc", PC_o, 32'h10C);

    // Stall three cycles while 0xDEADBEEF arrives, then release
    drive(1, 0, 0, '0, 32'hDEAD_BEEF); step();
    drive(1, 0, 0, '0, 32'h0BAD_0BAD); step();
    step();
    drive(1, 1, 0, '0, 32'h0BAD_0BAD); step();
    chk("stall_release_pc", PC_o, 32'h110);

    // Redirect in a ready cycle
    drive(1, 1, 1, 32'h200, 32'h2222_0000); step();
    chk("redirect_pc", PC_o, 32'h200);
    drive(1, 1, 0, '0, 32'h2222_0001); step();

    // 3-cycle latency, redirect on first wait cycle
    drive(0, 1, 1, 32'h300, 32'h3333_0000); step();
    drive(0, 1, 0, '0, 32'h3333_0001); step();
    drive(0, 1, 0, '0, 32'h3333_0002); step();
    drive(1, 1, 0, '0, 32'h3333_0003); step();
    chk("drop_resume_pc", PC_o, 32'h300);
    drive(1, 1, 0, '0, 32'h3333_0004); step();

    // Two redirects during one DROP, unaligned target gets masked
    drive(0, 1, 1, 32'h400, 32'h4444_0000); step();
    drive(0, 1, 1, 32'h503, 32'h4444_0001); step();
    drive(1, 1, 0, '0, 32'h4444_0002); step();
    chk("newest_redirect_pc", PC_o, 32'h500);

    // Wrap at the top of the address space
    drive(1, 1, 1, 32'hFFFF_FFFC, 32'h5555_0000); step();
    drive(1, 1, 0, '0, 32'h5555_0001); step();
    chk("wrap_pc", PC_o, 32'h0);

    // Reset in the middle of a wait
    drive(0, 1, 0, '0, 32'h6666_0000); step();
    rst_i = 1'b0; step();
    chk("midreset_pc", PC_o, RPC);
    rst_i = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, $urandom, $urandom);
      if ($urandom_range(0, 199) == 0) rst_i = 1'b0;
      else rst_i = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined CPU, directly upstream of the IF/ID pipeline register. It owns the program counter and drives a valid/ready instruction-memory handshake. It presents each fetched instruction, with its PC, to IF/ID, and inserts a NOP bubble whenever no valid instruction is available. It honours the hazard unit's PC-write stall and the EX-stage branch redirect, including a redirect that arrives while a memory request is still outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-low reset
- pc_write_i  in  1  hazard unit; 0 = stall and hold the PC and any captured instruction
- branch_i  in  1  taken branch/jump redirect; has priority over stall
- branch_target_i  in  32  redirect address, sampled when branch_i=1
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, equal to the current PC
- imem_ready_i  in  1  memory accepts request; imem_data_i valid in the same cycle
- imem_data_i  in  32  fetched instruction
- PC_o  out  32  PC of inst_o, to IF/ID
- inst_o  out  32  instruction to IF/ID; NOP (32'h0000_0013) when valid_o=0
- valid_o  out  1  inst_o carries a real instruction this cycle
- wait_cycles_o  out  32  only with FETCH_PERF_CNT_EN
- redirect_cnt_o  out  32  only with FETCH_PERF_CNT_EN

## Operation
- States:
  - FETCH: request outstanding at PC.
  - HOLD: instruction captured while stalled.
  - DROP: request outstanding but its result is stale.
- Handshake:
  - imem_req_o=1 in FETCH and DROP.
  - imem_addr_o is stable while imem_req_o=1 and imem_ready_i=0; a request is never withdrawn.
- FETCH with ready=1:
  - branch_i=1: discard data, valid_o=0, PC<=branch_target_i, stay FETCH.
  - pc_write_i=1: inst_o=imem_data_i, valid_o=1, PC<=PC+4, stay FETCH.
  - pc_write_i=0: inst_o=imem_data_i, valid_o=1, capture data into hold buffer, go HOLD.
- FETCH with ready=0:
  - branch_i=1: save target, go DROP.
  - Otherwise: valid_o=0, remain FETCH.
- HOLD:
  - No request.
  - inst_o=hold buffer, valid_o=1.
  - branch_i=1: drop buffer, PC<=target, go FETCH.
  - pc_write_i=1: PC<=PC+4, go FETCH.
  - Otherwise: remain HOLD.
- DROP:
  - valid_o=0.
  - branch_i=1 replaces the saved target (newest redirect wins).
  - On ready: discard data, PC<=saved target (or branch_target_i if branch_i is high that cycle), go FETCH.
- PC arithmetic:
  - 32-bit, wraps 32'hFFFF_FFFC -> 0.
  - Bits [1:0] are forced to 0 on every PC load.
- PC_o always equals the current PC register.

## Timing
- Reset (rst_i=0 at an edge):
  - PC<=RESET_PC, state FETCH, hold buffer cleared, counters 0.
  - While rst_i=0: imem_req_o=0, valid_o=0, inst_o=NOP.
- First request is issued in the first cycle with rst_i=1.
- Reset mid-request abandons the request; memory must tolerate this.
- Zero-wait memory: one instruction per cycle, zero-cycle combinational fetch latency (data to inst_o).
- Redirect penalty:
  - 1 bubble when the memory is ready in the redirect cycle.
  - 1 + remaining wait cycles when in DROP.
- Stall release: the held instruction is consumed in the release cycle; the next request is issued the following cycle.

## Configuration
- FETCH_PERF_CNT_EN defined: wait_cycles_o and redirect_cnt_o exist.
  - wait_cycles_o counts cycles with imem_req_o=1 and imem_ready_i=0.
  - redirect_cnt_o counts cycles with branch_i=1 and rst_i=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- FETCH_PERF_CNT_EN undefined: both ports and all counter logic are absent; other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - the NOP encoding constant (32'h0000_0013)
  - the 32-bit XLEN constant
  - the fetch state enum {FETCH, HOLD, DROP}
- One natural sub-module: fetch_perf_cnt (the two saturating counters), instantiated only under FETCH_PERF_CNT_EN.

## Test plan
- Reset release, RESET_PC=0x100, ready tied 1 -> PC_o 0x100, 0x104, 0x108 on consecutive cycles; inst_o follows imem_data_i; valid_o=1 from the first cycle after reset.
- pc_write_i=0 for 3 cycles while data 0xDEADBEEF arrives -> inst_o stays 0xDEADBEEF with valid_o=1 and no request; on release, PC advances by exactly 4.
- branch_i=1, target 0x200, in the ready cycle -> valid_o=0 that cycle; the next request address is 0x200.
- Memory with 3-cycle latency, branch_i to 0x300 in the 1st wait cycle -> imem_addr_o held constant until ready; returned data dropped; next request at 0x300.
- Two redirects (0x400, then 0x500) during one DROP -> fetch resumes at 0x500; with FETCH_PERF_CNT_EN, redirect_cnt_o=2.
- rst_i asserted mid-wait -> imem_req_o=0 next cycle; PC_o=RESET_PC; counters cleared.
